// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//   Multi-cycle restoring integer divider. Retires K quotient bits per clock,
//   so a normal division takes N/K CALC cycles plus one sign-fixup cycle.
//   Supports signed (truncating) and unsigned operation. Divide-by-zero and
//   signed overflow (most-negative / -1) bypass the iteration and complete
//   on the acceptance edge.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     operands and mode valid
//   in_ready     block idle, can accept an operation
//   in_signed    1 = two's-complement operands, 0 = unsigned
//   dividend     numerator   [N-1:0]
//   divisor      denominator [N-1:0]
//   out_valid    result valid (held until out_ready)
//   out_ready    consumer accepts the result
//   quotient     quotient    [N-1:0]
//   remainder    remainder   [N-1:0]
//   div_by_zero  divisor was zero
//   overflow     signed most-negative divided by -1
//
// Parameters
//   N  operand width (>= 4)
//   K  quotient bits per CALC cycle (1, 2 or 4; must divide N)
// -----------------------------------------------------------------------------
module seq_divider #(
  parameter int unsigned N = 32,
  parameter int unsigned K = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_signed,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero,
  output logic         overflow
);

  localparam int unsigned STEPS = N / K;
  localparam int unsigned CW    = $clog2(STEPS + 1);
  localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t         r_state;
  logic [2*N-1:0] r_acc;      // {partial remainder, dividend / quotient bits}
  logic [N-1:0]   r_div;      // divisor magnitude
  logic [CW-1:0]  r_cnt;
  logic           r_signed;
  logic           r_sign_q;
  logic           r_sign_r;

  logic           r_out_valid;
  logic [N-1:0]   r_quot;
  logic [N-1:0]   r_rem;
  logic           r_dbz;
  logic           r_ovf;

  logic           w_a_neg;
  logic           w_b_neg;
  logic [N-1:0]   w_a_mag;
  logic [N-1:0]   w_b_mag;
  logic           w_div_zero;
  logic           w_ovf_case;
  logic [2*N-1:0] w_acc_step;
  logic [N-1:0]   w_q_fix;
  logic [N-1:0]   w_r_fix;

  // Operand decode at the input boundary
  always_comb begin
    w_a_neg    = in_signed & dividend[N-1];
    w_b_neg    = in_signed & divisor[N-1];
    w_a_mag    = w_a_neg ? ('0 - dividend) : dividend;
    w_b_mag    = w_b_neg ? ('0 - divisor)  : divisor;
    w_div_zero = (divisor == '0);
    w_ovf_case = in_signed && (dividend == MOST_NEG) && (divisor == '1);
  end

  // K unrolled restoring steps. The bit shifted out of the top of the
  // accumulator is kept as a carry: the partial remainder can reach
  // 2*divisor-1, which needs N+1 bits when the divisor is large. A set carry
  // means the trial value exceeds any N-bit divisor, so no borrow is possible.
  always_comb begin
    logic         w_carry;
    logic [N:0]   w_diff;
    logic         w_borrow;
    w_carry    = 1'b0;
    w_diff     = '0;
    w_borrow   = 1'b0;
    w_acc_step = r_acc;
    for (int unsigned s = 0; s < K; s++) begin
      w_carry    = w_acc_step[2*N-1];
      w_acc_step = w_acc_step << 1;
      w_diff     = {w_carry, w_acc_step[2*N-1:N]} - {1'b0, r_div};
      w_borrow   = ~w_carry & w_diff[N];
      if (!w_borrow) begin
        w_acc_step[2*N-1:N] = w_diff[N-1:0];
        w_acc_step[0]       = 1'b1;
      end
    end
  end

  // Sign restoration of the magnitude result
  always_comb begin
    w_q_fix = (r_signed && r_sign_q) ? ('0 - r_acc[N-1:0])   : r_acc[N-1:0];
    w_r_fix = (r_signed && r_sign_r) ? ('0 - r_acc[2*N-1:N]) : r_acc[2*N-1:N];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_div       <= '0;
      r_cnt       <= '0;
      r_signed    <= 1'b0;
      r_sign_q    <= 1'b0;
      r_sign_r    <= 1'b0;
      r_out_valid <= 1'b0;
      r_quot      <= '0;
      r_rem       <= '0;
      r_dbz       <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            if (w_div_zero) begin
              r_quot      <= '1;
              r_rem       <= dividend;
              r_dbz       <= 1'b1;
              r_ovf       <= 1'b0;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else if (w_ovf_case) begin
              r_quot      <= dividend;
              r_rem       <= '0;
              r_dbz       <= 1'b0;
              r_ovf       <= 1'b1;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_acc    <= {{N{1'b0}}, w_a_mag};
              r_div    <= w_b_mag;
              r_cnt    <= CW'(STEPS);
              r_signed <= in_signed;
              r_sign_q <= w_a_neg ^ w_b_neg;
              r_sign_r <= w_a_neg;
              r_state  <= CALC;
            end
          end
        end

        CALC: begin
          r_acc <= w_acc_step;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            r_state <= FIX;
          end
        end

        FIX: begin
          r_quot      <= w_q_fix;
          r_rem       <= w_r_fix;
          r_dbz       <= 1'b0;
          r_ovf       <= 1'b0;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end

        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = r_out_valid;
  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;
  assign overflow    = r_ovf;

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
//   Two divider instances (K=1 and K=4, N=32) driven with directed and random
//   operations. Expected results come from plain integer division in the bench.
// -----------------------------------------------------------------------------
module tb_seq_divider;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    logic        ovf;
    int          lat;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid    [2];
  logic        in_ready    [2];
  logic        in_signed   [2];
  logic [31:0] dividend    [2];
  logic [31:0] divisor     [2];
  logic        out_valid   [2];
  logic        out_ready   [2];
  logic [31:0] quotient    [2];
  logic [31:0] remainder   [2];
  logic        div_by_zero [2];
  logic        overflow    [2];

  int checks = 0;
  int errors = 0;

  seq_divider #(.N(32), .K(1)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_signed(in_signed[0]),
    .dividend(dividend[0]), .divisor(divisor[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .quotient(quotient[0]), .remainder(remainder[0]),
    .div_by_zero(div_by_zero[0]), .overflow(overflow[0])
  );

  seq_divider #(.N(32), .K(4)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_signed(in_signed[1]),
    .dividend(dividend[1]), .divisor(divisor[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .quotient(quotient[1]), .remainder(remainder[1]),
    .div_by_zero(div_by_zero[1]), .overflow(overflow[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %0h expected %0h", nm, i, act, exp);
    end
  endtask

  // Reference: truncating integer division with the two special cases.
  // Latency counts edges from the acceptance edge (inclusive) to the edge
  // that raises out_valid.
  function automatic exp_t model(input logic sgn, input logic [31:0] a, input logic [31:0] b, input int k);
    exp_t e;
    int sa;
    int sb;
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    e.lat = 32 / k + 2;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF; e.r = a; e.dbz = 1'b1; e.lat = 1;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = a; e.r = 32'd0; e.ovf = 1'b1; e.lat = 1;
    end else if (sgn) begin
      sa = a; sb = b;
      e.q = sa / sb;
      e.r = sa % sb;
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  // Monitor state: pend/lat/exp_r/acc_id written at posedge, seen_id at negedge
  exp_t exp_r   [2];
  logic pend    [2];
  int   lat     [2];
  int   acc_id  [2];
  int   seen_id [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0; lat[i] = 0; acc_id[i] = 0; seen_id[i] = 0;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        pend[i] = 1'b0;
      end else begin
        if (pend[i]) lat[i]++;
        if (out_valid[i] && out_ready[i]) pend[i] = 1'b0;
        if (in_valid[i] && in_ready[i]) begin
          exp_r[i]  = model(in_signed[i], dividend[i], divisor[i], (i == 0) ? 1 : 4);
          pend[i]   = 1'b1;
          lat[i]    = 1;
          acc_id[i] = acc_id[i] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        chk("reset_data", i, {quotient[i], remainder[i]}, 64'd0);
        chk("reset_flags", i, {out_valid[i], in_ready[i], div_by_zero[i], overflow[i]}, 4'b0100);
      end else if (out_valid[i]) begin
        if (!pend[i]) begin
          chk("spurious_valid", i, out_valid[i], 0);
        end else begin
          if (seen_id[i] != acc_id[i]) begin
            seen_id[i] = acc_id[i];
            chk("latency", i, lat[i], exp_r[i].lat);
          end
          chk("quotient", i, quotient[i], exp_r[i].q);
          chk("remainder", i, remainder[i], exp_r[i].r);
          chk("flags", i, {div_by_zero[i], overflow[i]}, {exp_r[i].dbz, exp_r[i].ovf});
          chk("ready_in_done", i, in_ready[i], 0);
        end
      end else if (pend[i] && seen_id[i] != acc_id[i]) begin
        if (lat[i] >= exp_r[i].lat) begin
          seen_id[i] = acc_id[i];
          chk("valid_missing", i, out_valid[i], 1);
        end else begin
          chk("ready_while_busy", i, in_ready[i], 0);
        end
      end
    end
  end

  // Presents an operation and returns at the negedge after the acceptance
  // edge, leaving in_valid high with scrambled operands (must be ignored).
  task automatic issue(input int i, input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    @(negedge clk);
    in_signed[i] = sgn; dividend[i] = a; divisor[i] = b; in_valid[i] = 1'b1;
    while (!in_ready[i] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready[i]) begin
      chk("accept_timeout", i, in_ready[i], 1);
      in_valid[i] = 1'b0;
      return;
    end
    @(negedge clk);
    in_signed[i] = 1'($urandom_range(0, 1));
    dividend[i]  = $urandom;
    divisor[i]   = $urandom;
  endtask

  task automatic collect(input int i, input int hold, output logic [31:0] q, output logic [31:0] r,
                         output logic [1:0] fl, output int l);
    int n;
    n = 0; q = '0; r = '0; fl = '0; l = 0;
    while (!out_valid[i] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid[i]) begin
      chk("result_timeout", i, out_valid[i], 1);
      in_valid[i] = 1'b0;
      return;
    end
    q = quotient[i]; r = remainder[i]; fl = {div_by_zero[i], overflow[i]}; l = n + 1;
    repeat (hold) @(negedge clk);
    in_valid[i]  = 1'b0;
    out_ready[i] = 1'b1;
    @(negedge clk);
    out_ready[i] = 1'b0;
    chk("ready_after_hs", i, in_ready[i], 1);
    chk("valid_after_hs", i, out_valid[i], 0);
  endtask

  task automatic directed(input string nm, input int i, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input int hold, input logic [31:0] eq,
                          input logic [31:0] er, input logic [1:0] efl, input int elat);
    logic [31:0] q;
    logic [31:0] r;
    logic [1:0]  fl;
    int          l;
    issue(i, sgn, a, b);
    collect(i, hold, q, r, fl, l);
    chk({nm, "_q"}, i, q, eq);
    chk({nm, "_r"}, i, r, er);
    chk({nm, "_flags"}, i, fl, efl);
    chk({nm, "_lat"}, i, l, elat);
  endtask

  function automatic logic [31:0] rnd_val(input logic allow_zero);
    logic [31:0] v;
    case ($urandom_range(0, 6))
      0: v = $urandom;
      1: v = $urandom_range(1, 20);
      2: v = 32'h8000_0000;
      3: v = 32'hFFFF_FFFF;
      4: v = 32'd0 - $urandom_range(1, 20);
      5: v = allow_zero ? 32'd0 : 32'd3;
      default: v = $urandom >> $urandom_range(0, 31);
    endcase
    return v;
  endfunction

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] q;
    logic [31:0] r;
    logic [1:0]  fl;
    int          l;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0; in_signed[i] = 1'b0; dividend[i] = '0; divisor[i] = '0; out_ready[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    directed("u100_7",   0, 1'b0, 32'd100,         32'd7,         0, 32'd14,         32'd2,          2'b00, 34);
    directed("s_m7_2",   0, 1'b1, 32'hFFFF_FFF9,   32'd2,         1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  2'b00, 34);
    directed("u_m7_2",   0, 1'b0, 32'hFFFF_FFF9,   32'd2,         0, 32'h7FFF_FFFC,  32'd1,          2'b00, 34);
    directed("dz_s",     0, 1'b1, 32'h0000_1234,   32'd0,         2, 32'hFFFF_FFFF,  32'h0000_1234,  2'b10, 1);
    directed("dz_u",     0, 1'b0, 32'h0000_1234,   32'd0,         0, 32'hFFFF_FFFF,  32'h0000_1234,  2'b10, 1);
    directed("ovf_s",    0, 1'b1, 32'h8000_0000,   32'hFFFF_FFFF, 0, 32'h8000_0000,  32'd0,          2'b01, 1);
    directed("ovf_u",    0, 1'b0, 32'h8000_0000,   32'hFFFF_FFFF, 0, 32'd0,          32'h8000_0000,  2'b00, 34);
    directed("k4_ff_10", 1, 1'b0, 32'hFFFF_FFFF,   32'h10,        5, 32'h0FFF_FFFF,  32'hF,          2'b00, 10);

    // Reset during CALC cycle 5
    issue(0, 1'b0, 32'd100, 32'd7);
    in_valid[0] = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_data", 0, {quotient[0], remainder[0]}, 64'd0);
    chk("post_reset_flags", 0, {out_valid[0], in_ready[0], div_by_zero[0], overflow[0]}, 4'b0100);
    repeat (40) @(negedge clk);
    chk("post_reset_idle", 0, {out_valid[0], in_ready[0]}, 2'b01);
    directed("u9_3", 0, 1'b0, 32'd9, 32'd3, 0, 32'd3, 32'd0, 2'b00, 34);

    // Random operations; the monitor compares against the model every cycle
    for (int n = 0; n < 120; n++) begin
      for (int i = 0; i < 2; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        issue(i, 1'($urandom_range(0, 1)), rnd_val(1'b0), rnd_val(1'b1));
        collect(i, $urandom_range(0, 3), q, r, fl, l);
      end
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle, parametrised integer divider; successor to the team's single-cycle unrolled restoring divider.
- Processes K quotient bits per clock, so a result takes N/K iterations instead of N chained subtract stages.
- Adds signed/unsigned mode, valid/ready handshakes on both sides, and divide-by-zero and signed-overflow flags.
- Sits between an issuing datapath and a result consumer that can apply backpressure.

Parameters:
- N, 32, operand, quotient and remainder width; must be at least 4.
- K, 1, quotient bits retired per CALC cycle; must divide N; legal values 1, 2, 4.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and mode are valid.
- in_ready  output  1  block can accept a new operation.
- in_signed  input  1  1 = two's-complement operands, 0 = unsigned.
- dividend  input  N  numerator.
- divisor  input  N  denominator.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- quotient  output  N  quotient.
- remainder  output  N  remainder.
- div_by_zero  output  1  divisor was zero.
- overflow  output  1  signed most-negative divided by -1.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low on rst_n. While rst_n is 0:
  - state = IDLE
  - in_ready = 1 (after reset)
  - out_valid = 0
  - quotient, remainder, div_by_zero, overflow = 0
  - internal accumulator and counter cleared
- FSM states: IDLE, CALC, FIX, DONE.
- in_ready = 1 only in IDLE. An input is accepted on a clock edge where in_valid && in_ready.
- IDLE -> CALC on acceptance, normal case:
  - latch the magnitudes of the operands (absolute value when in_signed, raw value otherwise);
  - latch sign_q = sign(dividend) XOR sign(divisor), sign_r = sign(dividend);
  - load the counter with N/K.
- CALC: each cycle performs K restoring steps on a 2N-bit {partial remainder, dividend} register:
  - shift left by 1;
  - trial-subtract the divisor from the upper N bits (N+1-bit subtract so the borrow is visible);
  - borrow: restore and shift in quotient bit 0; no borrow: keep the difference and shift in 1.
  - Decrement the counter. When the counter reaches 0, go to FIX.
- FIX (1 cycle):
  - in_signed and sign_q: negate the quotient; in_signed and sign_r: negate the remainder.
  - Register the outputs, set out_valid, go to DONE.
- Latency, normal case: out_valid is high N/K + 2 rising edges after the acceptance edge (34 for N=32, K=1; 10 for K=4).
- Special cases skip CALC and FIX; IDLE -> DONE with out_valid high 1 edge after acceptance:
  - divisor == 0: quotient = all ones, remainder = dividend (unmodified), div_by_zero = 1, overflow = 0. This applies in both modes.
  - in_signed, dividend == 1 followed by N-1 zeros, divisor == all ones: quotient = dividend, remainder = 0, overflow = 1, div_by_zero = 0.
- DONE:
  - Outputs and flags are held stable while out_valid && !out_ready (backpressure may last any number of cycles).
  - On out_valid && out_ready: out_valid = 0, go to IDLE.
  - in_ready rises the cycle after the output handshake; the block does not accept and deliver in the same cycle.
  - quotient, remainder and flags keep their last values until the next result is registered.
- Input changes while busy are ignored. in_valid is irrelevant outside IDLE.
- Results must satisfy dividend = quotient*divisor + remainder (mod 2^N).
  - |remainder| < |divisor|.
  - Signed mode: the remainder is zero or has the dividend's sign (truncating division).
- Reset asserted mid-CALC, FIX or DONE: the operation is abandoned immediately; no out_valid pulse follows reset release.

Test Plan:
- Unsigned, N=32, K=1: dividend 100, divisor 7 -> quotient 14, remainder 2, flags 0, out_valid exactly 34 edges after acceptance; in_ready low throughout.
- Signed: dividend 0xFFFFFFF9 (-7), divisor 2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1). Same operands unsigned -> quotient 0x7FFFFFFC, remainder 1.
- Divisor 0, dividend 0x00001234, either mode -> quotient 0xFFFFFFFF, remainder 0x00001234, div_by_zero 1, out_valid 1 edge after acceptance.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0, overflow 1, latency 1 edge. The same operands unsigned -> quotient 0, remainder 0x80000000, overflow 0.
- K=4 build: 0xFFFFFFFF / 0x10 unsigned -> quotient 0x0FFFFFFF, remainder 0xF, latency 10. Hold out_ready low 5 cycles -> outputs stable, in_ready 0. Handshake, then in_ready 1 the next cycle.
- Assert rst_n low at cycle 5 of CALC for 3 cycles -> out_valid, outputs and flags 0 and in_ready 1 while reset is low and after release. A new 9/3 operation afterwards -> quotient 3, remainder 0.
